// File: rtl/ssc_pkg.sv
// Shared definitions for the spread-spectrum correlator sweep sequencer.
// Holds the channel register map, the FSM state enum and the bus bundle.
package ssc_pkg;

  localparam logic [31:0] REG_GLOBAL_RUN = 32'h0000_0100;
  localparam logic [31:0] REG_F_ADD      = 32'h0000_0380;
  localparam logic [31:0] REG_F_PHASE    = 32'h0000_0384;
  localparam logic [31:0] REG_F_CTRL     = 32'h0000_038c;
  localparam logic [31:0] REG_C_FREQ     = 32'h0000_0580;
  localparam logic [31:0] REG_C_PHASE    = 32'h0000_0584;
  localparam logic [31:0] REG_PRN        = 32'h0000_058c;
  localparam logic [31:0] REG_COR_LO     = 32'h0000_0784;
  localparam logic [31:0] REG_COR_HI     = 32'h0000_0788;
  localparam logic [31:0] REG_COR_STAT   = 32'h0000_078c;

  localparam logic [3:0]  CFG_LAST = 4'd8;

  localparam logic [63:0] MAG_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAG_MAX = 64'h7fff_ffff_ffff_ffff;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_WAIT,
    S_RD_LO,
    S_RD_HI,
    S_CLR,
    S_EVAL,
    S_NEXT,
    S_DONE
  } ssc_state_e;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  function automatic logic [63:0] sat_add64(
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? '1 : s[63:0];
  endfunction

endpackage

// File: rtl/ssc_mag_abs.sv
// Signed 64-bit correlation to unsigned magnitude, saturating the most
// negative value. Ports: val (signed in), mag (unsigned magnitude out).
module ssc_mag_abs
  import ssc_pkg::*;
(
  input  logic [63:0] val,
  output logic [63:0] mag
);

  always_comb begin
    mag = val;
    if (val == MAG_MIN) begin
      mag = MAG_MAX;
    end else if (val[63]) begin
      mag = -val;
    end
  end

endmodule

// File: rtl/ssc_sweep_ctrl.sv
// Sweep sequencer: programs each frequency bin, reads the correlation and
// keeps the max-magnitude bin. Ports: start/config in, busy/done/
// timeout_err/best_* out, addr/Wdata/write/read/Rdata/cseen channel bus.
// Optional macro SSC_DWELL_EN integrates DWELL events per bin.
module ssc_sweep_ctrl
  import ssc_pkg::*;
#(
  parameter int          NBINS_W = 8,
  parameter logic [31:0] TIMEOUT = 32'd1000000,
  parameter int          DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        f_start,
  input  logic [31:0]        f_step,
  input  logic [NBINS_W-1:0] n_bins,
  input  logic [31:0]        chip_freq,
  input  logic [31:0]        prn_cfg,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [NBINS_W-1:0] best_bin,
  output logic [63:0]        best_mag,
  output logic [31:0]        addr,
  output logic [31:0]        Wdata,
  output logic               write,
  output logic               read,
  input  logic [31:0]        Rdata,
  input  logic               cseen
);

`ifdef SSC_DWELL_EN
  localparam int EV_N = DWELL;
`else
  localparam int EV_N = 1;
`endif
  localparam int EV_W = $clog2(DWELL + 1);
  localparam logic [EV_W-1:0] EV_LAST = EV_W'(EV_N - 1);

  ssc_state_e         state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic               clr_ph_q, clr_ph_d;
  logic [31:0]        timer_q, timer_d;
  logic [NBINS_W-1:0] bin_q, bin_d;
  logic [NBINS_W-1:0] n_last_q, n_last_d;
  logic [31:0]        freq_q, freq_d;
  logic [31:0]        step_q, step_d;
  logic [31:0]        chip_q, chip_d;
  logic [31:0]        prn_q, prn_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_q, hi_d;
  logic [63:0]        acc_q, acc_d;
  logic [EV_W-1:0]    ev_q, ev_d;
  logic [NBINS_W-1:0] best_bin_q, best_bin_d;
  logic [63:0]        best_mag_q, best_mag_d;
  logic               terr_q, terr_d;
  bus_t               bus_q, bus_d;
  logic [63:0]        mag;

  ssc_mag_abs u_mag (
    .val (({hi_q, lo_q})),
    .mag (mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      widx_q     <= '0;
      clr_ph_q   <= 1'b0;
      timer_q    <= '0;
      bin_q      <= '0;
      n_last_q   <= '0;
      freq_q     <= '0;
      step_q     <= '0;
      chip_q     <= '0;
      prn_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      acc_q      <= '0;
      ev_q       <= '0;
      best_bin_q <= '0;
      best_mag_q <= '0;
      terr_q     <= 1'b0;
      bus_q      <= '0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      clr_ph_q   <= clr_ph_d;
      timer_q    <= timer_d;
      bin_q      <= bin_d;
      n_last_q   <= n_last_d;
      freq_q     <= freq_d;
      step_q     <= step_d;
      chip_q     <= chip_d;
      prn_q      <= prn_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      acc_q      <= acc_d;
      ev_q       <= ev_d;
      best_bin_q <= best_bin_d;
      best_mag_q <= best_mag_d;
      terr_q     <= terr_d;
      bus_q      <= bus_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    clr_ph_d   = clr_ph_q;
    timer_d    = timer_q;
    bin_d      = bin_q;
    n_last_d   = n_last_q;
    freq_d     = freq_q;
    step_d     = step_q;
    chip_d     = chip_q;
    prn_d      = prn_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    acc_d      = acc_q;
    ev_d       = ev_q;
    best_bin_d = best_bin_q;
    best_mag_d = best_mag_q;
    terr_d     = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          freq_d     = f_start;
          step_d     = f_step;
          chip_d     = chip_freq;
          prn_d      = prn_cfg;
          n_last_d   = (n_bins == '0) ? '0 : n_bins - 1'b1;
          bin_d      = '0;
          best_bin_d = '0;
          best_mag_d = '0;
          terr_d     = 1'b0;
          widx_d     = '0;
          acc_d      = '0;
          ev_d       = '0;
          state_d    = S_CFG;
        end
      end
      S_CFG: begin
        if (widx_q == CFG_LAST) begin
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          widx_d = widx_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (cseen) begin
          state_d = S_RD_LO;
        end else if (timer_q == TIMEOUT - 32'd1) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_RD_LO: begin
        lo_d    = Rdata;
        state_d = S_RD_HI;
      end
      S_RD_HI: begin
        hi_d     = Rdata;
        clr_ph_d = 1'b0;
        state_d  = S_CLR;
      end
      S_CLR: begin
        if (!clr_ph_q) begin
          // {hi,lo} is complete here; fold this event into the bin sum
          acc_d    = sat_add64(acc_q, mag);
          clr_ph_d = 1'b1;
        end else if (ev_q == EV_LAST) begin
          state_d = S_EVAL;
        end else begin
          ev_d    = ev_q + 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_EVAL: begin
        if (acc_q > best_mag_q) begin
          best_mag_d = acc_q;
          best_bin_d = bin_q;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (bin_q == n_last_q) begin
          state_d = S_DONE;
        end else begin
          bin_d   = bin_q + 1'b1;
          freq_d  = freq_q + step_q;
          widx_d  = '0;
          acc_d   = '0;
          ev_d    = '0;
          state_d = S_CFG;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus is registered: the access for a state is prepared on entry so the
  // strobe is high for exactly the cycles spent in that state.
  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    bus_d = '0;
    unique case (state_d)
      S_CFG: begin
        bus_d.wr = 1'b1;
        unique case (widx_d)
          4'd0: bus_d.addr = REG_GLOBAL_RUN;
          4'd1: begin
            bus_d.addr  = REG_F_ADD;
            bus_d.wdata = freq_d;
          end
          4'd2: bus_d.addr = REG_F_PHASE;
          4'd3: begin
            bus_d.addr  = REG_C_FREQ;
            bus_d.wdata = chip_d;
          end
          4'd4: bus_d.addr = REG_C_PHASE;
          4'd5: begin
            bus_d.addr  = REG_PRN;
            bus_d.wdata = prn_d;
          end
          4'd6: bus_d.addr = REG_COR_STAT;
          4'd7: begin
            bus_d.addr  = REG_F_CTRL;
            bus_d.wdata = 32'd1;
          end
          4'd8: begin
            bus_d.addr  = REG_GLOBAL_RUN;
            bus_d.wdata = 32'd1;
          end
          default: bus_d = '0;
        endcase
      end
      S_RD_LO: begin
        bus_d.rd   = 1'b1;
        bus_d.addr = REG_COR_LO;
      end
      S_RD_HI: begin
        bus_d.rd   = 1'b1;
        bus_d.addr = REG_COR_HI;
      end
      S_CLR: begin
        bus_d.wr   = clr_ph_d;
        bus_d.rd   = !clr_ph_d;
        bus_d.addr = REG_COR_STAT;
      end
      // every sweep end, normal or aborted, stops the channel
      S_DONE: begin
        bus_d.wr   = 1'b1;
        bus_d.addr = REG_GLOBAL_RUN;
      end
      default: bus_d = '0;
    endcase
  end

  assign timeout_err = terr_q;
  assign best_bin    = best_bin_q;
  assign best_mag    = best_mag_q;
  assign addr        = bus_q.addr;
  assign Wdata       = bus_q.wdata;
  assign write       = bus_q.wr;
  assign read        = bus_q.rd;

endmodule

// File: tb/tb_ssc_sweep_ctrl.sv
// Bench for ssc_sweep_ctrl: channel model, bus log and reference sweep model.
// Directed and $urandom sweeps; SSC_DWELL_EN adds the dwell case.
module tb_ssc_sweep_ctrl;

  localparam logic [31:0] TO = 32'd50;
`ifdef SSC_DWELL_EN
  localparam int EV = 4;
`else
  localparam int EV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] f_start, f_step, chip_freq, prn_cfg;
  logic [7:0]  n_bins;
  logic        busy, done, timeout_err;
  logic [7:0]  best_bin;
  logic [63:0] best_mag;
  logic [31:0] addr, Wdata, Rdata;
  logic        write, read;
  logic        cseen = 1'b0;

  typedef struct {
    logic [64:0] t;
    int          cyc;
  } ent_t;

  ent_t        log_q[$];
  logic [64:0] exp_q[$];
  logic [63:0] corr [0:255];
  logic [7:0]  ev = '0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          dly = 0;
  bit          run = 1'b0;
  bit          cs_off;
  int          cs_delay;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ssc_sweep_ctrl #(
    .NBINS_W (8),
    .TIMEOUT (TO),
    .DWELL   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .f_start     (f_start),
    .f_step      (f_step),
    .n_bins      (n_bins),
    .chip_freq   (chip_freq),
    .prn_cfg     (prn_cfg),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .best_bin    (best_bin),
    .best_mag    (best_mag),
    .addr        (addr),
    .Wdata       (Wdata),
    .write       (write),
    .read        (read),
    .Rdata       (Rdata),
    .cseen       (cseen)
  );

  always_comb begin
    Rdata = '0;
    if (read && addr == 32'h784) Rdata = corr[ev][31:0];
    else if (read && addr == 32'h788) Rdata = corr[ev][63:32];
  end

  // Channel model: cseen rises cs_delay cycles after run or status clear.
  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (rst) begin
      run = 1'b0;
      cseen = 1'b0;
      ev = '0;
    end else begin
      if (write || read) log_q.push_back('{t: {read, addr, Wdata}, cyc: cyc});
      if (write && addr == 32'h100) begin
        run = (Wdata == 32'd1);
        cseen = 1'b0;
        dly = cs_delay;
      end else if (read && addr == 32'h78c) begin
        cseen = 1'b0;
        ev++;
        dly = cs_delay;
      end else if (run && !cseen && !cs_off) begin
        if (dly <= 1) cseen = 1'b1;
        else dly--;
      end
      if (done) ev = '0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_mag(input logic [63:0] c);
    longint s;
    s = c;
    if (c == 64'h8000_0000_0000_0000) return 64'h7fff_ffff_ffff_ffff;
    return (s < 0) ? 64'(-s) : 64'(s);
  endfunction

  task automatic push_cfg(input logic [31:0] f, input logic [31:0] c,
                          input logic [31:0] p);
    exp_q.push_back({1'b0, 32'h100, 32'd0});
    exp_q.push_back({1'b0, 32'h380, f});
    exp_q.push_back({1'b0, 32'h384, 32'd0});
    exp_q.push_back({1'b0, 32'h580, c});
    exp_q.push_back({1'b0, 32'h584, 32'd0});
    exp_q.push_back({1'b0, 32'h58c, p});
    exp_q.push_back({1'b0, 32'h78c, 32'd0});
    exp_q.push_back({1'b0, 32'h38c, 32'd1});
    exp_q.push_back({1'b0, 32'h100, 32'd1});
  endtask

  task automatic sweep(input string tag, input logic [31:0] fs,
                       input logic [31:0] fst, input logic [7:0] nb,
                       input bit exp_to);
    int base, dbase, ne, n;
    bit seen, terr;
    logic [31:0] c, p, f;
    logic [63:0] sum, m, bmag;
    logic [7:0] bbin;
    c = $urandom;
    p = $urandom;
    f_start = fs;
    f_step = fst;
    n_bins = nb;
    chip_freq = c;
    prn_cfg = p;
    base = log_q.size();
    dbase = done_cnt;
    seen = 1'b0;
    terr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_start = $urandom;
    f_step = $urandom;
    n_bins = 8'($urandom);
    chip_freq = $urandom;
    prn_cfg = $urandom;
    for (int i = 0; i < 30000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        terr = timeout_err;
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    @(negedge clk);
    #1;
    check({tag, "_busy_after"}, busy, 1'b0);
    ne = (nb == 0) ? 1 : int'(nb);
    exp_q.delete();
    f = fs;
    sum = '0;
    bmag = '0;
    bbin = '0;
    for (int b = 0; b < ne; b++) begin
      push_cfg(f, c, p);
      f = f + fst;
      if (exp_to) break;
      sum = '0;
      for (int e = 0; e < EV; e++) begin
        exp_q.push_back({1'b1, 32'h784, 32'd0});
        exp_q.push_back({1'b1, 32'h788, 32'd0});
        exp_q.push_back({1'b1, 32'h78c, 32'd0});
        exp_q.push_back({1'b0, 32'h78c, 32'd0});
        m = ref_mag(corr[b * EV + e]);
        if (m > ~sum) sum = '1;
        else sum = sum + m;
      end
      if (sum > bmag) begin
        bmag = sum;
        bbin = 8'(b);
      end
    end
    exp_q.push_back({1'b0, 32'h100, 32'd0});
    n = log_q.size() - base;
    check({tag, "_bus_count"}, n, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < n; k++)
      check($sformatf("%s_bus%0d", tag, k), log_q[base + k].t, exp_q[k]);
    if (exp_to && n >= 10)
      check({tag, "_wait_cycles"},
            log_q[base + 9].cyc - log_q[base + 8].cyc, 51);
    check({tag, "_terr_at_done"}, terr, exp_to);
    check({tag, "_terr_hold"}, timeout_err, exp_to);
    check({tag, "_best_bin"}, best_bin, bbin);
    check({tag, "_best_mag"}, best_mag, bmag);
    check({tag, "_done_pulses"}, done_cnt - dbase, 1);
  endtask

  task automatic clr_corr();
    for (int i = 0; i < 256; i++) corr[i] = '0;
  endtask

  initial begin
    int base, n, dbase;
    longint sv;
    logic [7:0] nb;
    rst = 1'b1;
    start = 1'b0;
    f_start = '0;
    f_step = '0;
    n_bins = '0;
    chip_freq = '0;
    prn_cfg = '0;
    cs_off = 1'b0;
    cs_delay = 20;
    clr_corr();
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, timeout_err, write, read, best_bin}, '0);
    check("reset_bus", {addr, Wdata, best_mag}, '0);
    rst = 1'b0;
    @(negedge clk);

    corr[0 * EV] = 64'd5;
    corr[1 * EV] = -64'sd9;
    corr[2 * EV] = 64'd9;
    sweep("three_bins", 32'h1000, 32'h100, 8'd3, 1'b0);

    clr_corr();
    corr[0] = 64'h8000_0000_0000_0000;
    sweep("sat_min", 32'h2222, 32'h1, 8'd1, 1'b0);

    clr_corr();
    corr[0] = 64'd7;
    sweep("nbins_zero", 32'hffff_ff00, 32'h200, 8'd0, 1'b0);

    sweep("step_wrap", 32'hffff_ff80, 32'h80, 8'd2, 1'b0);

`ifdef SSC_DWELL_EN
    clr_corr();
    corr[0] = -64'sd2;
    corr[1] = 64'd3;
    corr[2] = -64'sd4;
    corr[3] = 64'd1;
    sweep("dwell", 32'h500, 32'h10, 8'd1, 1'b0);
`endif

    cs_off = 1'b1;
    sweep("timeout", 32'h3000, 32'h40, 8'd2, 1'b1);
    cs_off = 1'b0;

    for (int r = 0; r < 6; r++) begin
      clr_corr();
      nb = 8'($urandom_range(0, 4));
      cs_delay = $urandom_range(1, 30);
      for (int i = 0; i < 4 * EV; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          corr[i] = {$urandom, $urandom};
        end else begin
          sv = longint'($urandom_range(0, 20)) - 10;
          corr[i] = sv;
        end
      end
      sweep($sformatf("rand%0d", r), $urandom, $urandom, nb, 1'b0);
    end

    cs_off = 1'b1;
    cs_delay = 20;
    f_start = 32'h4000;
    f_step = 32'h8;
    n_bins = 8'd3;
    chip_freq = 32'h1234_5678;
    prn_cfg = 32'h9abc_def0;
    base = log_q.size();
    dbase = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && log_q.size() < base + 9; i++) @(negedge clk);
    exp_q.delete();
    push_cfg(32'h4000, 32'h1234_5678, 32'h9abc_def0);
    n = log_q.size() - base;
    check("rst_cfg_count", n, 9);
    for (int k = 0; k < 9 && k < n; k++)
      check($sformatf("rst_cfg%0d", k), log_q[base + k].t, exp_q[k]);
    check("rst_busy_wait", busy, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {busy, done, timeout_err, write, read, best_bin}, '0);
    check("rst_async_bus", {addr, Wdata, best_mag}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = log_q.size();
    repeat (12) @(negedge clk);
    check("rst_no_strobes", log_q.size(), n);
    check("rst_idle", busy, 1'b0);
    check("rst_no_done", done_cnt - dbase, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
